// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths, FSM states and mem_rw encodings for the RAM controller
package ram_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        RADDR,
        RWAIT,
        RSP
    } state_e;

endpackage

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - valid/ready byte access controller for the 4x8 binary-cell RAM
module ram_ctrl
    import ram_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE     = 8'h00,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter int                READ_WAIT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_busy,
    output logic              mem_s0,
    output logic              mem_s1,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0]        WAIT_LAST  = 8'(READ_WAIT - 1);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [7:0]          wait_q, wait_d;
    logic [ADDR_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_rw_q, mem_rw_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                init_busy_q, init_busy_d;
    logic                accept;

    // Every output is a flop, so the *_d values describe what the RAM sees next cycle.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        wait_d      = wait_q;
        sel_d       = sel_q;
        mem_data_d  = mem_data_q;
        mem_rw_d    = MEM_READ;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        init_busy_d = 1'b0;
        accept      = req_valid && req_ready_q;

        case (state_q)
            INIT: begin
                // Outputs trail the sweep counter by one edge; the last word is still
                // on the bus during the first IDLE cycle, where req_ready is still low.
                mem_rw_d    = MEM_WRITE;
                mem_data_d  = INIT_VALUE;
                sel_d       = sweep_q;
                init_busy_d = 1'b1;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE, RSP: begin
                if (accept) begin
                    sel_d = req_addr;
                    if (req_we) begin
                        state_d    = WRITE;
                        mem_rw_d   = MEM_WRITE;
                        mem_data_d = req_wdata;
                    end else begin
                        state_d = RADDR;
                    end
                end else begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end
            end
            WRITE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            RADDR: begin
                state_d = RWAIT;
                wait_d  = 8'd0;
            end
            RWAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d     = RSP;
                    rsp_rdata_d = mem_rdata;
                    rsp_valid_d = 1'b1;
                    req_ready_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? INIT : IDLE;
            sweep_q     <= '0;
            wait_q      <= 8'd0;
            sel_q       <= '0;
            mem_data_q  <= '0;
            mem_rw_q    <= MEM_READ;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_busy_q <= CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            wait_q      <= wait_d;
            sel_q       <= sel_d;
            mem_data_q  <= mem_data_d;
            mem_rw_q    <= mem_rw_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_busy = init_busy_q;
    assign mem_s0    = sel_q[0];
    assign mem_s1    = sel_q[1];
    assign mem_data  = mem_data_q;
    assign mem_rw    = mem_rw_q;

endmodule
